// File: rtl/rcc_rst_pkg.sv
// rtl/rcc_rst_pkg.sv - shared types and polarity helper for the RCC reset release sequencer
package rcc_rst_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        GAP  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Maps native polarity to "1 = hold in reset" and back; the mapping is its own inverse.
    function automatic logic rst_norm(input logic rst_native, input logic act_high);
        return act_high ? rst_native : ~rst_native;
    endfunction

endpackage

// File: rtl/rcc_rst_seq_mux_if.sv
// rtl/rcc_rst_seq_mux_if.sv - reset sequencer bus; RCC_RST_SEQ_STATUS_EN adds seq_ptr/seq_err
interface rcc_rst_seq_mux_if #(
    parameter int NUM_CH = 3
);
    localparam int PTR_W = $clog2(NUM_CH + 1);

    logic              testmode;
    logic              test_rst_n;
    logic [NUM_CH-1:0] raw_rst;
    logic [NUM_CH-1:0] rst_out;
    logic              seq_busy;
    logic              seq_done;
`ifdef RCC_RST_SEQ_STATUS_EN
    logic [PTR_W-1:0]  seq_ptr;
    logic              seq_err;

    modport master (
        output testmode, test_rst_n, raw_rst,
        input  rst_out, seq_busy, seq_done, seq_ptr, seq_err
    );
    modport slave (
        input  testmode, test_rst_n, raw_rst,
        output rst_out, seq_busy, seq_done, seq_ptr, seq_err
    );
`else
    modport master (
        output testmode, test_rst_n, raw_rst,
        input  rst_out, seq_busy, seq_done
    );
    modport slave (
        input  testmode, test_rst_n, raw_rst,
        output rst_out, seq_busy, seq_done
    );
`endif

endinterface

// File: rtl/rcc_rst_sync.sv
// rtl/rcc_rst_sync.sv - 1-bit async-assert / sync-deassert reset synchroniser
module rcc_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/rcc_rst_seq_mux.sv
// rtl/rcc_rst_seq_mux.sv - N-channel reset release sequencer with test override; option RCC_RST_SEQ_STATUS_EN
module rcc_rst_seq_mux
    import rcc_rst_pkg::*;
#(
    parameter int                NUM_CH        = 3,
    parameter logic [NUM_CH-1:0] ACT_HIGH_MASK = {NUM_CH{1'b1}},
    parameter int                SYNC_STAGES   = 2,
    parameter int                REL_GAP       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rcc_rst_seq_mux_if.slave     bus
);

    localparam int PTR_W = $clog2(NUM_CH + 1);
    localparam int CNT_W = $clog2(REL_GAP + 1);

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] clr_n;
    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] rel;

    seq_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, done_q;
    logic              rewind;
    logic [PTR_W-1:0]  rew_ptr;
    logic              free_cur, free_nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign req[g]   = rst_norm(bus.raw_rst[g], ACT_HIGH_MASK[g]);
        assign clr_n[g] = rst_n & ~req[g];

        rcc_rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst_n  (clr_n[g]),
            .sync_o (free[g])
        );

        // A drop on any lower channel re-holds this one at once, before the pointer rewinds.
        assign rel[g] = (ptr_q > PTR_W'(g)) & (&free[g:0]) & ~req[g];

        assign bus.rst_out[g] = bus.testmode ? rst_norm(~bus.test_rst_n, ACT_HIGH_MASK[g])
                                             : rst_norm(~rel[g], ACT_HIGH_MASK[g]);
    end

    always_comb begin
        rewind   = 1'b0;
        rew_ptr  = '0;
        free_cur = 1'b0;
        free_nxt = 1'b0;
        // Descending scan so the lowest dropped channel below ptr wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if ((PTR_W'(k) < ptr_q) && !free[k]) begin
                rewind  = 1'b1;
                rew_ptr = PTR_W'(k);
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (PTR_W'(k) == ptr_q) begin
                free_cur = free[k];
            end
            if ((k > 0) && (PTR_W'(k - 1) == ptr_q)) begin
                free_nxt = free[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            HOLD: begin
                if ((ptr_q < PTR_W'(NUM_CH)) && free_cur) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (!free_cur) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(REL_GAP - 1)) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = '0;
                    if (ptr_q == PTR_W'(NUM_CH - 1)) begin
                        state_d = DONE;
                    end else if (free_nxt) begin
                        state_d = GAP;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HOLD;
                ptr_d   = '0;
                cnt_d   = '0;
            end
        endcase
        if (rewind) begin
            state_d = HOLD;
            ptr_d   = rew_ptr;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == GAP);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.seq_busy = busy_q;
    assign bus.seq_done = done_q;

`ifdef RCC_RST_SEQ_STATUS_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | rewind;
        end
    end

    assign bus.seq_ptr = ptr_q;
    assign bus.seq_err = err_q;
`endif

endmodule

// File: tb/tb_rcc_rst_seq_mux.sv
// tb/tb_rcc_rst_seq_mux.sv - directed bench for rcc_rst_seq_mux, default and mixed-polarity instances
module tb_rcc_rst_seq_mux;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rcc_rst_seq_mux_if #(.NUM_CH(3)) ifa ();
    rcc_rst_seq_mux_if #(.NUM_CH(3)) ifb ();

    rcc_rst_seq_mux dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    rcc_rst_seq_mux #(.ACT_HIGH_MASK(3'b010)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edge 0 is the first edge that samples the released raw inputs.
    task automatic run_seq(input string tag);
        logic [2:0] hold;
        for (int n = 0; n <= 16; n++) begin
            step();
            hold = {1'(n < 14), 1'(n < 10), 1'(n < 6)};
            chk({tag, "_out_a"}, 32'(ifa.rst_out), 32'(hold));
            chk({tag, "_busy"}, 32'(ifa.seq_busy), 32'((n >= 2) && (n <= 13)));
            chk({tag, "_done"}, 32'(ifa.seq_done), 32'(n >= 14));
            chk({tag, "_out_b"}, 32'(ifb.rst_out), 32'(hold ^ 3'b101));
        end
    endtask

    initial begin
        logic [2:0] hold;
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        ifa.testmode    = 1'b0;
        ifa.test_rst_n  = 1'b1;
        ifa.raw_rst     = 3'b111;
        ifb.testmode    = 1'b0;
        ifb.test_rst_n  = 1'b1;
        ifb.raw_rst     = 3'b010;
        #1;
        chk("reset_out_a", 32'(ifa.rst_out), 32'h7);
        chk("reset_out_b", 32'(ifb.rst_out), 32'h2);
        chk("reset_busy", 32'(ifa.seq_busy), 32'h0);
        chk("reset_done", 32'(ifa.seq_done), 32'h0);
`ifdef RCC_RST_SEQ_STATUS_EN
        chk("reset_ptr", 32'(ifa.seq_ptr), 32'h0);
        chk("reset_err", 32'(ifa.seq_err), 32'h0);
`endif
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step();
            chk("held_out_a", 32'(ifa.rst_out), 32'h7);
            chk("held_busy", 32'(ifa.seq_busy), 32'h0);
        end
        ifa.raw_rst = 3'b000;
        ifb.raw_rst = 3'b101;
        run_seq("seq1");
`ifdef RCC_RST_SEQ_STATUS_EN
        chk("done_ptr", 32'(ifa.seq_ptr), 32'h3);
        chk("done_err", 32'(ifa.seq_err), 32'h0);
`endif

        // Channel 1 pulse after completion: 1 and 2 drop together, 0 stays released.
        ifa.raw_rst = 3'b010;
        #1;
        chk("pulse1_comb_out", 32'(ifa.rst_out), 32'h6);
        step();
        chk("pulse1_done_clr", 32'(ifa.seq_done), 32'h0);
        chk("pulse1_busy", 32'(ifa.seq_busy), 32'h0);
`ifdef RCC_RST_SEQ_STATUS_EN
        chk("pulse1_ptr", 32'(ifa.seq_ptr), 32'h1);
        chk("pulse1_err", 32'(ifa.seq_err), 32'h1);
`endif
        ifa.raw_rst = 3'b000;
        for (int m = 1; m <= 12; m++) begin
            step();
            hold = {1'(m < 11), 1'(m < 7), 1'b0};
            chk("reseq1_out", 32'(ifa.rst_out), 32'(hold));
            chk("reseq1_busy", 32'(ifa.seq_busy), 32'((m >= 3) && (m <= 10)));
            chk("reseq1_done", 32'(ifa.seq_done), 32'(m >= 11));
        end
        chk("reseq1_out_b", 32'(ifb.rst_out), 32'h5);

        // Channel 0 pulse, then test override once ptr==1.
        ifa.raw_rst = 3'b001;
        #1;
        chk("pulse0_comb_out", 32'(ifa.rst_out), 32'h7);
        step();
        ifa.raw_rst = 3'b000;
        for (int m = 1; m <= 7; m++) begin
            step();
        end
        chk("mid_out", 32'(ifa.rst_out), 32'h6);
        ifa.testmode   = 1'b1;
        ifb.testmode   = 1'b1;
        ifa.test_rst_n = 1'b0;
        ifb.test_rst_n = 1'b0;
        #1;
        chk("tm0_out_a", 32'(ifa.rst_out), 32'h7);
        chk("tm0_out_b", 32'(ifb.rst_out), 32'h2);
        ifa.test_rst_n = 1'b1;
        ifb.test_rst_n = 1'b1;
        #1;
        chk("tm1_out_a", 32'(ifa.rst_out), 32'h0);
        chk("tm1_out_b", 32'(ifb.rst_out), 32'h5);
        chk("tm_busy", 32'(ifa.seq_busy), 32'h1);
        ifa.test_rst_n = 1'b0;
        #1;
        chk("tm0b_out_a", 32'(ifa.rst_out), 32'h7);
        ifa.testmode = 1'b0;
        ifb.testmode = 1'b0;
        #1;
        chk("tm_exit_out_a", 32'(ifa.rst_out), 32'h6);
        chk("tm_exit_out_b", 32'(ifb.rst_out), 32'h5);

        // Block reset while ptr==1 in GAP.
        step();
        chk("pre_rst_busy", 32'(ifa.seq_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_a", 32'(ifa.rst_out), 32'h7);
        chk("arst_out_b", 32'(ifb.rst_out), 32'h2);
        chk("arst_busy", 32'(ifa.seq_busy), 32'h0);
        chk("arst_done", 32'(ifa.seq_done), 32'h0);
`ifdef RCC_RST_SEQ_STATUS_EN
        chk("arst_ptr", 32'(ifa.seq_ptr), 32'h0);
        chk("arst_err", 32'(ifa.seq_err), 32'h0);
`endif
        rst_n = 1'b1;
        #1;
        run_seq("seq2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
